// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, sequencer states and counter sizing for the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  function automatic int cnt_bits(input int w);
    return $clog2(w) + 1;
  endfunction
  localparam int CNT_W = cnt_bits(32);
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the shared adder/subtractor
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_o
);
  logic [WIDTH+1:0] a, b, s;
  // divide trial-subtracts from the shifted remainder; multiply conditionally adds into the upper half
  always_comb begin
    a = div_i ? {1'b0, acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]} : {2'b0, acc_i[2*WIDTH-1:WIDTH]};
    b = div_i ? -{2'b0, opnd_i} : (acc_i[0] ? {2'b0, opnd_i} : '0);
    s = a + b;
    q_o = div_i & ~s[WIDTH+1];
    acc_o = div_i ? {(q_o ? s[WIDTH-1:0] : a[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0}
                  : {s[WIDTH:0], acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = cnt_bits(WIDTH);
  state_e state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0] opnd, rs_raw, rs_mag, rt_mag, quot, rem;
  logic is_div, neg_q, neg_r, dz, q, sgn, div_op, accept;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc),
    .opnd_i(opnd),
    .div_i(is_div),
    .acc_o(acc_nx),
    .q_o(q)
  );

  // operand magnitudes, acceptance and sign-corrected final results
  always_comb begin
    sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
    div_op = (op_i == OP_DIVU) || (op_i == OP_DIV);
    rs_mag = (sgn && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
    rt_mag = (sgn && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;
    accept = start_i && (state == IDLE || state == DONE);
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // sequencer: capture, WIDTH iterations, sign fix, then publish to HI/LO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      rs_raw <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      div_zero_o <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      done_o <= 1'b0;
      div_zero_o <= 1'b0;
      if (!busy_o && hi_we_i) hi_o <= wdata_i;
      if (!busy_o && lo_we_i) lo_o <= wdata_i;
      case (state)
        IDLE, DONE: begin
          state <= accept ? CALC : IDLE;
          if (accept) begin
            busy_o <= 1'b1;
            cnt <= '0;
            is_div <= div_op;
            neg_q <= sgn && (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
            neg_r <= sgn && div_op && rs_data_i[WIDTH-1];
            dz <= div_op && (rt_data_i == '0);
            rs_raw <= rs_data_i;
            opnd <= div_op ? rt_mag : rs_mag;
            acc <= {{WIDTH{1'b0}}, (div_op ? rs_mag : rt_mag)};
          end
        end
        CALC: begin
          acc <= {acc_nx[2*WIDTH-1:1], acc_nx[0] | q};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          div_zero_o <= dz;
          if (!is_div) {hi_o, lo_o} <= prod;
          else if (dz) begin
            hi_o <= rs_raw;
            lo_o <= '1;
          end else begin
            hi_o <= rem;
            lo_o <= quot;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
  localparam int W = 32;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, hi_we_i = 1'b0, lo_we_i = 1'b0;
  logic [1:0] op_i = 2'b00;
  logic [31:0] rs_data_i = '0, rt_data_i = '0, wdata_i = '0;
  logic busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;
  int total = 0, bad = 0;

  always #5 clk_i = ~clk_i;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .op_i(op_i),
    .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i),
    .hi_we_i(hi_we_i),
    .lo_we_i(lo_we_i),
    .wdata_i(wdata_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .div_zero_o(div_zero_o),
    .hi_o(hi_o),
    .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint a, b, q, r;
    logic [63:0] u;
    ez = 1'b0;
    eh = '0;
    el = '0;
    if (op == 2'd0) begin
      u = {32'b0, rs} * {32'b0, rt};
      eh = u[63:32];
      el = u[31:0];
    end else if (op == 2'd1) begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
      u = 64'(a * b);
      eh = u[63:32];
      el = u[31:0];
    end else if (rt == 32'd0) begin
      ez = 1'b1;
      eh = rs;
      el = '1;
    end else if (op == 2'd2) begin
      el = rs / rt;
      eh = rs % rt;
    end else begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
      q = a / b;
      r = a % b;
      u = 64'(q);
      el = u[31:0];
      u = 64'(r);
      eh = u[31:0];
    end
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    start_i = 1'b1;
    op_i = op;
    rs_data_i = rs;
    rt_data_i = rt;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    op_i = 2'($urandom);
    rs_data_i = $urandom;
    rt_data_i = $urandom;
  endtask

  task automatic wait_done(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input string tag, input int poke);
    logic [31:0] eh, el, h0, l0;
    logic ez, hold;
    int n, nb;
    model(op, rs, rt, eh, el, ez);
    h0 = hi_o;
    l0 = lo_o;
    hold = 1'b1;
    n = 0;
    nb = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (busy_o) nb++;
      if (!done_o && (hi_o !== h0 || lo_o !== l0)) hold = 1'b0;
      if (poke > 0 && n == poke) begin
        start_i = 1'b1;
        op_i = 2'd0;
        rs_data_i = 32'd100;
        rt_data_i = 32'd100;
        hi_we_i = 1'b1;
        lo_we_i = 1'b1;
        wdata_i = 32'hDEADBEEF;
      end
      if (poke > 0 && n == poke + 1) begin
        start_i = 1'b0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
      end
    end while (!done_o && n < 100);
    chk({tag, "_latency"}, n, W + 2);
    chk({tag, "_busy_cycles"}, nb, W + 1);
    chk({tag, "_hold"}, {31'b0, hold}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_hi"}, hi_o, eh);
    chk({tag, "_lo"}, lo_o, el);
    chk({tag, "_div_zero"}, {31'b0, div_zero_o}, {31'b0, ez});
  endtask

  initial begin
    logic [1:0] rop;
    logic [31:0] rrs, rrt;
    int dones;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_dz", {31'b0, div_zero_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    lo_we_i = 1'b1;
    wdata_i = 32'hAAAA5555;
    @(negedge clk_i);
    lo_we_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'hAAAA5555);
    chk("mtlo_hi", hi_o, 32'd0);
    hi_we_i = 1'b1;
    lo_we_i = 1'b1;
    wdata_i = 32'h12345678;
    @(negedge clk_i);
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    chk("mtboth_hi", hi_o, 32'h12345678);
    chk("mtboth_lo", lo_o, 32'h12345678);
    launch(2'd1, 32'hFFFFFFFE, 32'h3);
    wait_done(2'd1, 32'hFFFFFFFE, 32'h3, "mult", 0);
    chk("mult_hi_const", hi_o, 32'hFFFFFFFF);
    chk("mult_lo_const", lo_o, 32'hFFFFFFFA);
    @(negedge clk_i);
    chk("mult_done_one_cycle", {31'b0, done_o}, 32'd0);
    launch(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu", 0);
    chk("multu_hi_const", hi_o, 32'hFFFFFFFE);
    chk("multu_lo_const", lo_o, 32'h00000001);
    @(negedge clk_i);
    launch(2'd3, 32'hFFFFFFF9, 32'h2);
    wait_done(2'd3, 32'hFFFFFFF9, 32'h2, "div_neg", 0);
    chk("div_neg_lo_const", lo_o, 32'hFFFFFFFD);
    chk("div_neg_hi_const", hi_o, 32'hFFFFFFFF);
    @(negedge clk_i);
    launch(2'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(2'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 0);
    chk("div_ovf_lo_const", lo_o, 32'h80000000);
    chk("div_ovf_hi_const", hi_o, 32'h0);
    @(negedge clk_i);
    launch(2'd2, 32'h1234, 32'h0);
    wait_done(2'd2, 32'h1234, 32'h0, "divu_zero", 0);
    chk("divu_zero_hi_const", hi_o, 32'h1234);
    chk("divu_zero_lo_const", lo_o, 32'hFFFFFFFF);
    chk("divu_zero_flag_const", {31'b0, div_zero_o}, 32'd1);
    @(negedge clk_i);
    chk("dz_pulse_one_cycle", {31'b0, div_zero_o}, 32'd0);
    launch(2'd3, 32'h80000005, 32'h0);
    wait_done(2'd3, 32'h80000005, 32'h0, "div_zero_signed", 0);
    launch(2'd0, 32'd3, 32'd4);
    wait_done(2'd0, 32'd3, 32'd4, "b2b_first", 0);
    launch(2'd2, 32'd100, 32'd7);
    wait_done(2'd2, 32'd100, 32'd7, "b2b_second", 0);
    @(negedge clk_i);
    launch(2'd0, 32'd7, 32'd6);
    wait_done(2'd0, 32'd7, 32'd6, "ignored_start", 5);
    chk("ignored_start_lo_const", lo_o, 32'd42);
    @(negedge clk_i);
    chk("ignored_start_idle_busy", {31'b0, busy_o}, 32'd0);
    chk("ignored_start_idle_done", {31'b0, done_o}, 32'd0);
    lo_we_i = 1'b1;
    wdata_i = 32'hCAFEF00D;
    launch(2'd2, 32'd1000, 32'd10);
    lo_we_i = 1'b0;
    chk("mt_at_start_lo", lo_o, 32'hCAFEF00D);
    wait_done(2'd2, 32'd1000, 32'd10, "mt_at_start", 0);
    @(negedge clk_i);
    launch(2'd1, 32'd123, 32'd456);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_idle_busy", {31'b0, busy_o}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      rrs = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rrt = ($urandom_range(0, 6) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      launch(rop, rrs, rrt);
      wait_done(rop, rrs, rrt, "rand", 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk_i);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the MIPS datapath, executing MULT, MULTU, DIV and DIVU over multiple cycles and owning the HI/LO registers read by MFHI/MFLO. One shared adder/subtractor is reused each iteration: shift-add for multiply, restoring subtract for divide. Sits beside the ALU in EX. The hazard logic stalls the pipeline on busy_o.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  launch operation; sampled only in IDLE or DONE
op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data_i  input  WIDTH  multiplicand / dividend
rt_data_i  input  WIDTH  multiplier / divisor
hi_we_i  input  1  MTHI write strobe
lo_we_i  input  1  MTLO write strobe
wdata_i  input  WIDTH  MTHI/MTLO data
busy_o  output  1  operation in progress
done_o  output  1  one-cycle pulse when HI/LO are updated
div_zero_o  output  1  pulses with done_o when a divide had divisor 0
hi_o  output  WIDTH  HI register
lo_o  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state including mid-operation): state IDLE, iteration counter 0, hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0. Any partial result is discarded.
- States:
  - IDLE -> CALC on start_i.
  - CALC runs WIDTH cycles, then -> FIX.
  - FIX runs 1 cycle, then -> DONE.
  - DONE runs 1 cycle. If start_i is high it goes -> CALC, otherwise -> IDLE.
- Latency: start_i accepted at edge T. busy_o=1 during cycles T+1..T+WIDTH+1 (CALC+FIX). HI/LO update at edge T+WIDTH+2. done_o=1 for that single cycle (DONE), with busy_o=0.
- Back-to-back: start_i in DONE is accepted; done_o still pulses for that cycle.
- Start during busy: start_i while busy_o=1 is ignored, and operands are not resampled.
- Operand capture: op, rs and rt are latched at acceptance. Signed ops (MULT/DIV) take two's-complement magnitudes and record the result signs. Unsigned ops use the operands as-is.
- Multiply: 2*WIDTH-bit product, one add-and-shift per CALC cycle. FIX negates the product if the operand signs differ. HI gets product[2W-1:W], LO gets product[W-1:0].
- Divide: restoring, one trial subtract per CALC cycle. FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend was negative. LO gets the quotient, HI gets the remainder.
- Divide by zero: the full CALC/FIX timing is still taken. Result is HI=rs (original, unsigned view), LO=all ones, div_zero_o=1 with done_o.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0. No trap.
- MTHI/MTLO: hi_we_i / lo_we_i write wdata_i at the clock edge when busy_o=0.
  - A write in the same cycle as an accepted start is performed, and is later overwritten at completion.
  - A write while busy_o=1 is dropped.
  - Simultaneous hi_we_i and lo_we_i write both registers.
- hi_o and lo_o hold their value at all times except at the completion edge and MT writes. They never show intermediate values.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MULTU/MULT/DIVU/DIV;
  - state enum IDLE/CALC/FIX/DONE;
  - counter width constant clog2(WIDTH)+1.
- One natural sub-module, muldiv_step: a combinational single iteration. It takes the partial remainder/product, operand and mode, and returns the next partial value plus the divide quotient bit. It encapsulates the shared adder/subtractor.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=0x00000003 -> done_o exactly WIDTH+2 cycles after the start edge; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy_o high for exactly 33 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- DIVU rs=0x00001234, rt=0 -> HI=0x00001234, LO=0xFFFFFFFF, div_zero_o=1 in the same cycle as done_o.
- Robustness:
  - MTLO 0xAAAA5555 in IDLE -> lo_o=0xAAAA5555 next cycle.
  - A start_i pulse at CALC cycle 5 of a MULTU 7*6 -> ignored; LO=42.
  - rst_i asserted at CALC cycle 10 -> busy_o=0, hi_o=lo_o=0 immediately, with no done_o pulse.
